// File: rtl/cue_strike_ctrl.sv
// Cue-strike controller: the power ramps while charge is held, and the strike fires on release.
// The latched cue vector is scaled by power and clamped, then one collision pulse is issued.
//
// state    | meaning
// IDLE     | waiting for charge with the table at rest; power forced to 0
// CHARGE   | power ramps by one step every CHARGE_DIV held cycles
// MUL      | latched cue vector multiplied by the latched power
// SCALE    | product divided (rounded toward zero) and clamped to +/-VMAX
// FIRE     | collision pulse with valid velocity outputs
// COOLDOWN | lockout until minimum time has passed and no ball is moving
`timescale 1ns/1ps
module cue_strike_ctrl #(
   parameter int COORD_W      = 11,
   parameter int POWER_W      = 7,
   parameter int POWER_MAX    = 100,
   parameter int CHARGE_DIV   = 4,
   parameter int POWER_SHIFT  = 4,
   parameter int VEL_W        = 16,
   parameter int VMAX         = 512,
   parameter int COOLDOWN_CYC = 8
) (
   input  logic               clk,
   input  logic               resetN,
   input  logic [COORD_W-1:0] closeEdgeX,
   input  logic [COORD_W-1:0] closeEdgeY,
   input  logic [COORD_W-1:0] farEdgeX,
   input  logic [COORD_W-1:0] farEdgeY,
   input  logic               charge,
   input  logic               abort,
   input  logic               balls_moving,
   output logic [VEL_W-1:0]   ball_vx_next,
   output logic [VEL_W-1:0]   ball_vy_next,
   output logic               collision,
   output logic [POWER_W-1:0] power,
   output logic               ready
);

   localparam int CW1  = COORD_W + 1;
   localparam int PW   = CW1 + POWER_W + 1;
   localparam int AW   = ((PW > VEL_W) ? PW : VEL_W) + 1;
   localparam int PS_W = (CHARGE_DIV > 1) ? $clog2(CHARGE_DIV) : 1;
   localparam int CD_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;

   localparam logic [PS_W-1:0]      PS_LAST = PS_W'(CHARGE_DIV - 1);
   localparam logic [CD_W-1:0]      CD_LAST = CD_W'(COOLDOWN_CYC - 1);
   localparam logic [POWER_W-1:0]   PMAX    = POWER_W'(POWER_MAX);
   localparam logic signed [AW-1:0] RND     = AW'((1 << POWER_SHIFT) - 1);
   localparam logic signed [AW-1:0] VMAXS   = AW'(VMAX);

   typedef enum logic [2:0] {
      S_IDLE, S_CHARGE, S_MUL, S_SCALE, S_FIRE, S_COOLDOWN
   } state_t;

   state_t                  state_q;
   logic [POWER_W-1:0]      power_q;
   logic [PS_W-1:0]         presc_q;
   logic [CD_W-1:0]         cd_q;
   logic [CW1-1:0]          dx_q, dy_q;
   logic signed [PW-1:0]    px_q, py_q;
   logic [VEL_W-1:0]        vx_q, vy_q;
   logic                    coll_q;

   logic [CW1-1:0]          dx_d, dy_d;
   logic signed [PW-1:0]    dx_ext, dy_ext, pw_ext;
   logic signed [PW-1:0]    px_d, py_d;

   assign dx_d   = {closeEdgeX[COORD_W-1], closeEdgeX} - {farEdgeX[COORD_W-1], farEdgeX};
   assign dy_d   = {closeEdgeY[COORD_W-1], closeEdgeY} - {farEdgeY[COORD_W-1], farEdgeY};
   assign dx_ext = {{(PW-CW1){dx_q[CW1-1]}}, dx_q};
   assign dy_ext = {{(PW-CW1){dy_q[CW1-1]}}, dy_q};
   assign pw_ext = {{(PW-POWER_W){1'b0}}, power_q};
   assign px_d   = dx_ext * pw_ext;
   assign py_d   = dy_ext * pw_ext;

   // Bias negatives before the arithmetic shift so the quotient rounds toward zero.
   function automatic logic [VEL_W-1:0] scale_clamp(input logic signed [PW-1:0] p);
      logic signed [AW-1:0] e;
      logic signed [AW-1:0] q;
      e = {{(AW-PW){p[PW-1]}}, p};
      if (e < 0) e = e + RND;
      q = e >>> POWER_SHIFT;
      if (q > VMAXS)       q = VMAXS;
      else if (q < -VMAXS) q = -VMAXS;
      return q[VEL_W-1:0];
   endfunction

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         state_q <= S_IDLE;
         power_q <= '0;
         presc_q <= '0;
         cd_q    <= '0;
         dx_q    <= '0;
         dy_q    <= '0;
         px_q    <= '0;
         py_q    <= '0;
         vx_q    <= '0;
         vy_q    <= '0;
         coll_q  <= 1'b0;
      end else begin
         coll_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               power_q <= '0;
               if (charge && !balls_moving) begin
                  presc_q <= '0;
                  state_q <= S_CHARGE;
               end
            end
            S_CHARGE: begin
               if (abort) begin
                  power_q <= '0;
                  state_q <= S_IDLE;
               end else if (!charge) begin
                  if (power_q == '0) begin
                     state_q <= S_IDLE;
                  end else begin
                     dx_q    <= dx_d;
                     dy_q    <= dy_d;
                     state_q <= S_MUL;
                  end
               end else if (presc_q == PS_LAST) begin
                  presc_q <= '0;
                  if (power_q != PMAX) power_q <= power_q + 1'b1;
               end else begin
                  presc_q <= presc_q + 1'b1;
               end
            end
            S_MUL: begin
               px_q    <= px_d;
               py_q    <= py_d;
               state_q <= S_SCALE;
            end
            S_SCALE: begin
               vx_q    <= scale_clamp(px_q);
               vy_q    <= scale_clamp(py_q);
               coll_q  <= 1'b1;
               state_q <= S_FIRE;
            end
            S_FIRE: begin
               cd_q    <= '0;
               state_q <= S_COOLDOWN;
            end
            S_COOLDOWN: begin
               // Saturate so a long wait on moving balls cannot wrap the counter.
               if (cd_q != '1) cd_q <= cd_q + 1'b1;
               if (cd_q >= CD_LAST && !balls_moving) begin
                  power_q <= '0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ball_vx_next = vx_q;
   assign ball_vy_next = vy_q;
   assign collision    = coll_q;
   assign power        = power_q;
   assign ready        = (state_q == S_IDLE) && !balls_moving;

endmodule

// File: tb/tb_cue_strike_ctrl.sv
// Directed and random cue strikes checked against an arithmetic model of power ramp,
// velocity scaling and cooldown timing.
`timescale 1ns/1ps
module tb_cue_strike_ctrl;
   localparam int COORD_W      = 11;
   localparam int POWER_W      = 7;
   localparam int POWER_MAX    = 100;
   localparam int CHARGE_DIV   = 4;
   localparam int POWER_SHIFT  = 4;
   localparam int VEL_W        = 16;
   localparam int VMAX         = 512;
   localparam int COOLDOWN_CYC = 8;

   logic               clk = 1'b0;
   logic               resetN;
   logic [COORD_W-1:0] closeEdgeX, closeEdgeY, farEdgeX, farEdgeY;
   logic               charge, abort, balls_moving;
   logic [VEL_W-1:0]   ball_vx_next, ball_vy_next;
   logic               collision;
   logic [POWER_W-1:0] power;
   logic               ready;

   int passed = 0;
   int total  = 0;
   int coll_cnt = 0;
   int last_vx = 0;
   int last_vy = 0;

   cue_strike_ctrl #(
      .COORD_W(COORD_W), .POWER_W(POWER_W), .POWER_MAX(POWER_MAX),
      .CHARGE_DIV(CHARGE_DIV), .POWER_SHIFT(POWER_SHIFT), .VEL_W(VEL_W),
      .VMAX(VMAX), .COOLDOWN_CYC(COOLDOWN_CYC)
   ) dut (
      .clk(clk), .resetN(resetN),
      .closeEdgeX(closeEdgeX), .closeEdgeY(closeEdgeY),
      .farEdgeX(farEdgeX), .farEdgeY(farEdgeY),
      .charge(charge), .abort(abort), .balls_moving(balls_moving),
      .ball_vx_next(ball_vx_next), .ball_vy_next(ball_vy_next),
      .collision(collision), .power(power), .ready(ready)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (collision === 1'b1) coll_cnt++;

   initial begin
      #2ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic signed [31:0] obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   function automatic int vel_model(input int d, input int p);
      int q;
      q = (d * p) / (1 << POWER_SHIFT);
      if (q > VMAX)  q = VMAX;
      if (q < -VMAX) q = -VMAX;
      return q;
   endfunction

   function automatic int rnd_coord();
      return int'($urandom_range(0, 2047)) - 1024;
   endfunction

   task automatic set_geom(input int cx, input int cy, input int fx, input int fy);
      closeEdgeX = COORD_W'(cx);
      closeEdgeY = COORD_W'(cy);
      farEdgeX   = COORD_W'(fx);
      farEdgeY   = COORD_W'(fy);
   endtask

   task automatic shot(input int cx, input int cy, input int fx, input int fy,
                       input int hold, input int bm_cycles);
      int pw, c0, n, exp_n;
      pw = hold / CHARGE_DIV;
      if (pw > POWER_MAX) pw = POWER_MAX;
      chk("ready_pre", ready, 1);
      set_geom(cx, cy, fx, fy);
      abort = 1'b0;
      charge = 1'b1;
      tick();
      for (int i = 0; i < hold; i++) tick();
      chk("power_charge", power, pw);
      charge = 1'b0;
      c0 = coll_cnt;
      tick();
      if (pw == 0) begin
         chk("ready_zero", ready, 1);
         chk("power_zero", power, 0);
         tick(); tick(); tick(); tick();
         chk("vx_unchanged", $signed(ball_vx_next), last_vx);
         chk("vy_unchanged", $signed(ball_vy_next), last_vy);
         chk("no_coll_zero", coll_cnt, c0);
         return;
      end
      set_geom(rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord());
      chk("coll_mul", collision, 0);
      chk("power_hold", power, pw);
      tick();
      chk("coll_scale", collision, 0);
      tick();
      last_vx = vel_model(cx - fx, pw);
      last_vy = vel_model(cy - fy, pw);
      chk("coll_fire", collision, 1);
      chk("vx", $signed(ball_vx_next), last_vx);
      chk("vy", $signed(ball_vy_next), last_vy);
      tick();
      chk("coll_after", collision, 0);
      chk("ready_cool", ready, 0);
      n = 0;
      while (n < 400) begin
         balls_moving = (n < bm_cycles);
         #1;
         if (ready) break;
         tick();
         n++;
      end
      exp_n = (bm_cycles + 1 > COOLDOWN_CYC) ? bm_cycles + 1 : COOLDOWN_CYC;
      chk("cooldown_len", n, exp_n);
      chk("power_idle", power, 0);
      chk("vx_hold", $signed(ball_vx_next), last_vx);
      chk("pulse_count", coll_cnt, c0 + 1);
   endtask

   initial begin
      int c0;
      resetN = 1'b0;
      charge = 1'b0;
      abort = 1'b0;
      balls_moving = 1'b0;
      set_geom(0, 0, 0, 0);
      #23;
      chk("rst_vx", $signed(ball_vx_next), 0);
      chk("rst_vy", $signed(ball_vy_next), 0);
      chk("rst_coll", collision, 0);
      chk("rst_power", power, 0);
      chk("rst_ready", ready, 1);
      resetN = 1'b1;
      tick();

      shot(300, 200, 260, 230, 64, 0);
      shot(0, 7, 7, 0, 20, 0);
      shot(500, -200, 100, 200, 1000, 0);
      shot(10, 10, -5, 3, 2, 0);

      c0 = coll_cnt;
      charge = 1'b1;
      tick();
      for (int i = 0; i < 40; i++) tick();
      chk("abort_pre_power", power, 10);
      abort = 1'b1;
      tick();
      chk("abort_power", power, 0);
      chk("abort_ready", ready, 1);
      charge = 1'b0;
      abort = 1'b0;
      for (int i = 0; i < 6; i++) tick();
      chk("abort_no_coll", coll_cnt, c0);

      balls_moving = 1'b1;
      charge = 1'b1;
      for (int i = 0; i < 12; i++) tick();
      chk("bm_ready", ready, 0);
      chk("bm_power", power, 0);
      charge = 1'b0;
      tick();
      balls_moving = 1'b0;
      #1;
      chk("bm_ready_after", ready, 1);
      chk("bm_no_coll", coll_cnt, c0);

      shot(-300, 400, 0, 0, 100, 50);

      c0 = coll_cnt;
      set_geom(900, 900, 100, 100);
      charge = 1'b1;
      tick();
      for (int i = 0; i < 40; i++) tick();
      charge = 1'b0;
      tick();
      resetN = 1'b0;
      #1;
      chk("rstmul_vx", $signed(ball_vx_next), 0);
      chk("rstmul_vy", $signed(ball_vy_next), 0);
      chk("rstmul_coll", collision, 0);
      chk("rstmul_power", power, 0);
      tick(); tick();
      resetN = 1'b1;
      tick();
      chk("rstmul_ready", ready, 1);
      for (int i = 0; i < 6; i++) tick();
      chk("rstmul_no_coll", coll_cnt, c0);
      last_vx = 0;
      last_vy = 0;
      chk("rstmul_vx_after", $signed(ball_vx_next), 0);

      for (int k = 0; k < 8; k++) begin
         int bm;
         bm = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 20)) : 0;
         shot(rnd_coord(), rnd_coord(), rnd_coord(), rnd_coord(),
              int'($urandom_range(0, 480)), bm);
         tick();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/cue_strike_ctrl.md
Name: cue_strike_ctrl

Overview:
Parametrised cue-strike controller for the pool table. It replaces the single-shot cue collision logic with a charge/release state machine: power ramps while the player holds charge and the strike fires on release. Cue geometry is latched at release, and ball velocity is computed in a 2-stage pipeline with truncation and saturation. The block issues a one-cycle collision pulse to the cue-ball physics, then locks out further shots until cooldown expires and the table is at rest.

Parameters:
COORD_W, 11, signed width of cue edge coordinates
POWER_W, 7, width of power level
POWER_MAX, 100, power saturation value (must be < 2^POWER_W)
CHARGE_DIV, 4, cycles in CHARGE per +1 power
POWER_SHIFT, 4, velocity divisor = 2^POWER_SHIFT
VEL_W, 16, signed width of velocity outputs
VMAX, 512, velocity magnitude clamp (must be < 2^(VEL_W-1))
COOLDOWN_CYC, 8, minimum cycles in COOLDOWN

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
closeEdgeX  in  COORD_W  signed cue tip X
closeEdgeY  in  COORD_W  signed cue tip Y
farEdgeX  in  COORD_W  signed cue butt X
farEdgeY  in  COORD_W  signed cue butt Y
charge  in  1  level; held = charging, release = strike
abort  in  1  cancel charge
balls_moving  in  1  high while any ball has nonzero velocity
ball_vx_next  out  VEL_W  signed strike velocity X
ball_vy_next  out  VEL_W  signed strike velocity Y
collision  out  1  one-cycle strike pulse
power  out  POWER_W  current charge level
ready  out  1  high when state==IDLE and balls_moving==0

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (resetN).
- Reset values: state=IDLE; ball_vx_next=0; ball_vy_next=0; collision=0; power=0; prescaler=0; cooldown counter=0.
- All state is registered. ready is the only combinational output.
- States: IDLE, CHARGE, MUL, SCALE, FIRE, COOLDOWN.
- IDLE:
  - power=0.
  - charge=1 && balls_moving=0 -> CHARGE, prescaler cleared.
  - charge ignored while balls_moving=1.
- CHARGE, per cycle, priority abort > release > count:
  - abort=1 -> IDLE, power<=0, no pulse.
  - charge=0 && power==0 -> IDLE, no pulse.
  - charge=0 && power>0 -> latch dx=closeEdgeX-farEdgeX, dy=closeEdgeY-farEdgeY (COORD_W+1 bits signed) and power; go to MUL.
  - charge=1 -> prescaler++. When prescaler==CHARGE_DIV-1: prescaler<=0 and power<=min(power+1, POWER_MAX).
  - balls_moving is ignored in CHARGE.
- MUL: px=dx*power, py=dy*power, full-width signed and registered. -> SCALE. abort is ignored (shot committed).
- SCALE:
  - q = p / 2^POWER_SHIFT, truncated toward zero (not an arithmetic shift: -35/16 = -2).
  - Clamp q to [-VMAX, +VMAX] and register into ball_vx_next/ball_vy_next. -> FIRE.
- FIRE:
  - collision=1 for exactly this one cycle; velocity outputs are already valid in this cycle.
  - -> COOLDOWN with counter cleared.
- Velocity outputs hold their value until the next SCALE or reset.
- COOLDOWN:
  - counter++ each cycle.
  - Leave to IDLE (power<=0) only when counter>=COOLDOWN_CYC-1 and balls_moving=0. Otherwise wait indefinitely.
- Latency: the release cycle (charge sampled 0 in CHARGE) is cycle N; collision is high in cycle N+3.
- power output: tracks the charge count in CHARGE; holds the latched value through MUL to COOLDOWN; returns to 0 in IDLE.
- Geometry changes after the release edge do not affect the shot in flight.
- Reset mid-operation (any state): immediate return to reset values, no pulse.
- charge held through COOLDOWN into IDLE starts a new CHARGE only if balls_moving=0.

Test Plan:
- close(300,200), far(260,230), charge held 64 cycles in CHARGE, then released -> power=16, collision high exactly 3 cycles after release, vx=+40, vy=-30; ready=0 until cooldown ends.
- dx=-7, dy=+7, power=5 (hold 20 cycles) -> vx=-2, vy=+2 (truncation toward zero on both signs).
- dx=+400, dy=-400, charge held 1000 cycles -> power saturates at 100; vx=+512, vy=-512 (clamped).
- Charge released after 2 cycles (power 0) -> back to IDLE, no collision, outputs unchanged. Abort at power=10 -> IDLE, power=0, no collision.
- balls_moving=1 in IDLE with charge=1 -> stays IDLE, ready=0. After a shot, balls_moving held high 50 cycles -> COOLDOWN lasts until balls_moving drops (≥8 cycles), then ready=1.
- resetN asserted during MUL -> ball_vx_next=0, ball_vy_next=0, collision never pulses, state IDLE after release of reset.
